// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB pipeline register: issues data-memory accesses over a
// req/done handshake, stalls upstream while one is outstanding, and flags bad accesses.
module mem_wb_stage #(
  parameter int DW      = 16,
  parameter int RW      = 3,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_alu_data,
  input  logic [DW-1:0] ex_st_data,
  input  logic [DW-1:0] ex_pc_plus2,
  input  logic [1:0]    ex_sel_wbreg,
  input  logic          ex_mem_rd,
  input  logic          ex_mem_wr,
  input  logic          ex_reg_wr,
  input  logic [RW-1:0] ex_wr_reg,
  input  logic          ex_halt,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_done,
  output logic          mem_stall,
  output logic          wb_valid,
  output logic [1:0]    wb_sel_wbreg,
  output logic [DW-1:0] wb_pc_plus2,
  output logic [DW-1:0] wb_alu_data,
  output logic [DW-1:0] wb_mem_out,
  output logic          wb_reg_wr,
  output logic [RW-1:0] wb_wr_reg,
  output logic          wb_halt,
  output logic          wb_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t        state_reg, state_next;
  logic [7:0]    cnt_reg, cnt_next;

  // Copy of the instruction in flight, so upstream may be frozen or change freely.
  logic [DW-1:0] hold_alu_reg, hold_st_reg, hold_pc2_reg;
  logic [1:0]    hold_sel_reg;
  logic          hold_rd_reg, hold_wr_reg, hold_reg_wr_reg, hold_halt_reg;
  logic [RW-1:0] hold_wr_reg_reg;
  logic          hold_load;

  logic          mem_op, misaligned, issue;

  logic          wb_valid_next, wb_err_next, wb_reg_wr_next, wb_halt_next;
  logic [1:0]    wb_sel_next;
  logic [DW-1:0] wb_pc2_next, wb_alu_next, wb_mem_next;
  logic [RW-1:0] wb_wr_reg_next;

  assign mem_op     = ex_valid & (ex_mem_rd | ex_mem_wr);
  assign misaligned = ex_alu_data[0];
  // Held off during reset so no request can leak out while rst is high.
  assign issue      = mem_op & ~misaligned & ~rst;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    hold_load      = 1'b0;
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    dmem_addr      = '0;
    dmem_wdata     = '0;
    mem_stall      = 1'b0;
    wb_valid_next  = 1'b0;
    wb_err_next    = 1'b0;
    wb_reg_wr_next = 1'b0;
    wb_halt_next   = 1'b0;
    wb_sel_next    = '0;
    wb_pc2_next    = '0;
    wb_alu_next    = '0;
    wb_mem_next    = '0;
    wb_wr_reg_next = '0;
    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (issue) begin
          dmem_req   = 1'b1;
          dmem_we    = ex_mem_wr;
          dmem_addr  = ex_alu_data;
          dmem_wdata = ex_st_data;
          mem_stall  = 1'b1;
          hold_load  = 1'b1;
          state_next = S_WAIT;
        end else begin
          wb_valid_next  = ex_valid;
          wb_sel_next    = ex_sel_wbreg;
          wb_pc2_next    = ex_pc_plus2;
          wb_alu_next    = ex_alu_data;
          wb_wr_reg_next = ex_wr_reg;
          wb_halt_next   = ex_halt;
          wb_reg_wr_next = ex_reg_wr & ~mem_op;
          wb_err_next    = mem_op;
        end
      end
      S_WAIT: begin
        dmem_we        = hold_wr_reg;
        dmem_addr      = hold_alu_reg;
        dmem_wdata     = hold_st_reg;
        wb_sel_next    = hold_sel_reg;
        wb_pc2_next    = hold_pc2_reg;
        wb_alu_next    = hold_alu_reg;
        wb_wr_reg_next = hold_wr_reg_reg;
        wb_halt_next   = hold_halt_reg;
        if (dmem_done) begin
          wb_valid_next  = 1'b1;
          wb_reg_wr_next = hold_reg_wr_reg;
          wb_mem_next    = hold_rd_reg ? dmem_rdata : '0;
          cnt_next       = '0;
          state_next     = S_IDLE;
        end else if (cnt_reg == TIMEOUT_CNT) begin
          // Abandon: retire as an error so upstream can move on this cycle.
          wb_valid_next  = 1'b1;
          wb_err_next    = 1'b1;
          cnt_next       = '0;
          state_next     = S_IDLE;
        end else begin
          // Still waiting: MEM/WB receives a bubble.
          wb_sel_next    = '0;
          wb_pc2_next    = '0;
          wb_alu_next    = '0;
          wb_wr_reg_next = '0;
          wb_halt_next   = 1'b0;
          mem_stall      = 1'b1;
          cnt_next       = cnt_reg + 8'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_alu_reg    <= '0;
      hold_st_reg     <= '0;
      hold_pc2_reg    <= '0;
      hold_sel_reg    <= '0;
      hold_rd_reg     <= 1'b0;
      hold_wr_reg     <= 1'b0;
      hold_reg_wr_reg <= 1'b0;
      hold_halt_reg   <= 1'b0;
      hold_wr_reg_reg <= '0;
    end else if (hold_load) begin
      hold_alu_reg    <= ex_alu_data;
      hold_st_reg     <= ex_st_data;
      hold_pc2_reg    <= ex_pc_plus2;
      hold_sel_reg    <= ex_sel_wbreg;
      hold_rd_reg     <= ex_mem_rd;
      hold_wr_reg     <= ex_mem_wr;
      hold_reg_wr_reg <= ex_reg_wr;
      hold_halt_reg   <= ex_halt;
      hold_wr_reg_reg <= ex_wr_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_err       <= 1'b0;
      wb_reg_wr    <= 1'b0;
      wb_halt      <= 1'b0;
      wb_sel_wbreg <= '0;
      wb_pc_plus2  <= '0;
      wb_alu_data  <= '0;
      wb_mem_out   <= '0;
      wb_wr_reg    <= '0;
    end else begin
      wb_valid     <= wb_valid_next;
      wb_err       <= wb_err_next;
      wb_reg_wr    <= wb_reg_wr_next;
      wb_halt      <= wb_halt_next;
      wb_sel_wbreg <= wb_sel_next;
      wb_pc_plus2  <= wb_pc2_next;
      wb_alu_data  <= wb_alu_next;
      wb_mem_out   <= wb_mem_next;
      wb_wr_reg    <= wb_wr_reg_next;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected MEM/WB records are queued when an
// instruction is driven and compared when wb_valid appears.
module tb_mem_wb_stage;

  localparam int DW      = 16;
  localparam int RW      = 3;
  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] st;
    logic [15:0] pc2;
    logic [1:0]  sel;
    logic        rd;
    logic        wr;
    logic        reg_wr;
    logic [2:0]  wr_reg;
    logic        halt;
  } op_t;

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] pc2;
    logic [15:0] alu;
    logic [15:0] mem;
    logic        reg_wr;
    logic [2:0]  wr_reg;
    logic        halt;
    logic        err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ex_valid = 1'b0;
  logic [DW-1:0] ex_alu_data = '0, ex_st_data = '0, ex_pc_plus2 = '0;
  logic [1:0]    ex_sel_wbreg = '0;
  logic          ex_mem_rd = 1'b0, ex_mem_wr = 1'b0, ex_reg_wr = 1'b0, ex_halt = 1'b0;
  logic [RW-1:0] ex_wr_reg = '0;
  logic          dmem_req, dmem_we, mem_stall;
  logic [DW-1:0] dmem_addr, dmem_wdata;
  logic [DW-1:0] dmem_rdata = '0;
  logic          dmem_done = 1'b0;
  logic          wb_valid, wb_reg_wr, wb_halt, wb_err;
  logic [1:0]    wb_sel_wbreg;
  logic [DW-1:0] wb_pc_plus2, wb_alu_data, wb_mem_out;
  logic [RW-1:0] wb_wr_reg;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t mon_exp;

  mem_wb_stage #(.DW(DW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_data(ex_alu_data), .ex_st_data(ex_st_data),
    .ex_pc_plus2(ex_pc_plus2), .ex_sel_wbreg(ex_sel_wbreg),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr),
    .ex_wr_reg(ex_wr_reg), .ex_halt(ex_halt),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_done(dmem_done),
    .mem_stall(mem_stall),
    .wb_valid(wb_valid), .wb_sel_wbreg(wb_sel_wbreg), .wb_pc_plus2(wb_pc_plus2),
    .wb_alu_data(wb_alu_data), .wb_mem_out(wb_mem_out), .wb_reg_wr(wb_reg_wr),
    .wb_wr_reg(wb_wr_reg), .wb_halt(wb_halt), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Writeback monitor: every wb_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (sb.size() == 0) begin
        check_eq("wb_unexpected", {31'd0, wb_valid}, 32'd0);
      end else begin
        mon_exp = sb.pop_front();
        check_eq("wb_sel",    {30'd0, wb_sel_wbreg}, {30'd0, mon_exp.sel});
        check_eq("wb_pc2",    {16'd0, wb_pc_plus2},  {16'd0, mon_exp.pc2});
        check_eq("wb_alu",    {16'd0, wb_alu_data},  {16'd0, mon_exp.alu});
        check_eq("wb_mem",    {16'd0, wb_mem_out},   {16'd0, mon_exp.mem});
        check_eq("wb_reg_wr", {31'd0, wb_reg_wr},    {31'd0, mon_exp.reg_wr});
        check_eq("wb_wr_reg", {29'd0, wb_wr_reg},    {29'd0, mon_exp.wr_reg});
        check_eq("wb_halt",   {31'd0, wb_halt},      {31'd0, mon_exp.halt});
        check_eq("wb_err",    {31'd0, wb_err},       {31'd0, mon_exp.err});
        $display("WB alu=%04h mem=%04h pc2=%04h sel=%0d rd=%0d rw=%0b halt=%0b err=%0b",
                 wb_alu_data, wb_mem_out, wb_pc_plus2, wb_sel_wbreg, wb_wr_reg,
                 wb_reg_wr, wb_halt, wb_err);
      end
    end
  end

  task automatic drive_op(input op_t op);
    ex_valid     = 1'b1;
    ex_alu_data  = op.alu;
    ex_st_data   = op.st;
    ex_pc_plus2  = op.pc2;
    ex_sel_wbreg = op.sel;
    ex_mem_rd    = op.rd;
    ex_mem_wr    = op.wr;
    ex_reg_wr    = op.reg_wr;
    ex_wr_reg    = op.wr_reg;
    ex_halt      = op.halt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ex_valid  = 1'b0;
      ex_mem_rd = 1'b0;
      ex_mem_wr = 1'b0;
      dmem_done = 1'b0;
    end
  endtask

  // done_after: cycles after the request cycle that dmem_done is raised; <0 = never.
  task automatic run_op(input op_t op, input int done_after, input logic [15:0] rdata);
    exp_t e;
    int   cyc, stalls, reqs, exp_stalls;
    bit   memop, mis, iss, timed_out;
    memop     = op.rd | op.wr;
    mis       = op.alu[0];
    iss       = memop & !mis;
    timed_out = iss && (done_after < 0 || done_after > TIMEOUT + 1);
    exp_stalls = !iss ? 0 : (timed_out ? TIMEOUT + 1 : done_after);
    e.sel    = op.sel;
    e.pc2    = op.pc2;
    e.alu    = op.alu;
    e.wr_reg = op.wr_reg;
    e.halt   = op.halt;
    e.err    = (memop & mis) | timed_out;
    e.reg_wr = e.err ? 1'b0 : op.reg_wr;
    e.mem    = (op.rd && iss && !timed_out) ? rdata : 16'h0000;
    @(posedge clk); #1;
    drive_op(op);
    dmem_done  = 1'b0;
    dmem_rdata = rdata;
    sb.push_back(e);
    cyc = 0; stalls = 0; reqs = 0;
    forever begin
      @(negedge clk);
      if (dmem_req) reqs++;
      if (iss) begin
        check_eq("dmem_addr",  {16'd0, dmem_addr},  {16'd0, op.alu});
        check_eq("dmem_wdata", {16'd0, dmem_wdata}, {16'd0, op.st});
        check_eq("dmem_we",    {31'd0, dmem_we},    {31'd0, op.wr});
      end
      if (!mem_stall) break;
      stalls++;
      if (cyc >= 40) begin
        check_eq("op_bound", {31'd0, mem_stall}, 32'd0);
        break;
      end
      @(posedge clk); #1;
      cyc++;
      dmem_done = (done_after == cyc);
    end
    check_eq("req_count",    reqs,   {31'd0, iss});
    check_eq("stall_cycles", stalls, exp_stalls);
  endtask

  function automatic op_t mk_op(input logic [15:0] alu, input logic [15:0] st,
                                input logic [15:0] pc2, input logic [1:0] sel,
                                input logic rd, input logic wr, input logic reg_wr,
                                input logic [2:0] wr_reg, input logic halt);
    op_t o;
    o.alu = alu; o.st = st; o.pc2 = pc2; o.sel = sel; o.rd = rd; o.wr = wr;
    o.reg_wr = reg_wr; o.wr_reg = wr_reg; o.halt = halt;
    return o;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check_eq("rst_wb_valid",  {31'd0, wb_valid},  32'd0);
    check_eq("rst_wb_err",    {31'd0, wb_err},    32'd0);
    check_eq("rst_dmem_req",  {31'd0, dmem_req},  32'd0);
    check_eq("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
    check_eq("rst_wb_alu",    {16'd0, wb_alu_data}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    idle(1);

    // ALU op, link op, halt then non-halt
    run_op(mk_op(16'h1234, 16'h0000, 16'h0102, 2'b01, 0, 0, 1, 3'd3, 0), -1, 16'h0);
    run_op(mk_op(16'h5555, 16'h0000, 16'h0A0C, 2'b10, 0, 0, 1, 3'd7, 0), -1, 16'h0);
    run_op(mk_op(16'h0000, 16'h0000, 16'h0200, 2'b11, 0, 0, 0, 3'd0, 1), -1, 16'h0);
    run_op(mk_op(16'h0F0F, 16'h0000, 16'h0202, 2'b01, 0, 0, 1, 3'd1, 0), -1, 16'h0);
    idle(1);
    // Load, done 3 cycles after request
    run_op(mk_op(16'h0040, 16'h0000, 16'h0300, 2'b00, 1, 0, 1, 3'd5, 0), 3, 16'hBEEF);
    idle(1);
    // Store, done next cycle
    run_op(mk_op(16'h0010, 16'h00AA, 16'h0400, 2'b00, 0, 1, 0, 3'd0, 0), 1, 16'h7777);
    idle(1);
    // Misaligned load
    run_op(mk_op(16'h0041, 16'h0000, 16'h0500, 2'b00, 1, 0, 1, 3'd2, 0), 1, 16'h1111);
    idle(1);
    // Timeout: done never arrives
    run_op(mk_op(16'h0080, 16'h0000, 16'h0600, 2'b00, 1, 0, 1, 3'd4, 0), -1, 16'h2222);
    // Back-to-back load then store, no idle between
    run_op(mk_op(16'h0022, 16'h0000, 16'h0700, 2'b00, 1, 0, 1, 3'd6, 0), 2, 16'h1357);
    run_op(mk_op(16'h0024, 16'hC0DE, 16'h0702, 2'b00, 0, 1, 0, 3'd0, 0), 5, 16'h0000);
    // Done on the timeout boundary still completes
    run_op(mk_op(16'h0030, 16'h0000, 16'h0800, 2'b00, 1, 0, 1, 3'd2, 0), TIMEOUT + 1, 16'hA5A5);
    idle(2);

    // Reset during WAIT, followed by a stray dmem_done
    @(posedge clk); #1;
    drive_op(mk_op(16'h0060, 16'h0000, 16'h0900, 2'b00, 1, 0, 1, 3'd3, 0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("wait_stall", {31'd0, mem_stall}, 32'd1);
    rst = 1'b1;
    ex_valid = 1'b0;
    #1;
    check_eq("rstw_mem_stall", {31'd0, mem_stall}, 32'd0);
    check_eq("rstw_dmem_req",  {31'd0, dmem_req},  32'd0);
    check_eq("rstw_dmem_addr", {16'd0, dmem_addr}, 32'd0);
    check_eq("rstw_wb_valid",  {31'd0, wb_valid},  32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    dmem_done  = 1'b1;
    dmem_rdata = 16'hDEAD;
    @(negedge clk);
    check_eq("stray_stall", {31'd0, mem_stall}, 32'd0);
    check_eq("stray_req",   {31'd0, dmem_req},  32'd0);
    @(posedge clk); #1 dmem_done = 1'b0;
    @(negedge clk);
    check_eq("stray_wb_valid", {31'd0, wb_valid}, 32'd0);
    run_op(mk_op(16'h4321, 16'h0000, 16'h0A00, 2'b01, 0, 0, 1, 3'd3, 0), -1, 16'h0);
    idle(3);

    check_eq("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
